bram_capture_pp: RTL and testbench
==================================

BRAM_CAPTURE_PP -- requirements
Module: bram_capture_pp

Interface
REQ-001 Parameter DATA_W, default 32, sample width per channel in bits; the legal range is 1..32.
REQ-002 Parameter N_CH, default 2, number of channels per input sample; the legal values are 1, 2, 4 and 8.
REQ-003 Parameter ADDR_W, default 10, log2 of bank depth in 32-bit words (DEPTH = 2^ADDR_W).
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 arm  in  1  level; capture is enabled while high.
REQ-007 valid  in  1  one-cycle strobe marking a new multi-channel sample on datos.
REQ-008 datos  in  N_CH*DATA_W  sample data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 rel_ack  in  1  one-cycle strobe from the reader releasing the bank given by rel_bank.
REQ-010 rel_bank  in  1  index of the bank being released.
REQ-011 enable  out  1  BRAM port enable.
REQ-012 we  out  1  BRAM write enable.
REQ-013 addr  out  32  BRAM byte address.
REQ-014 din  out  32  BRAM write data, zero-extended from DATA_W.
REQ-015 frame_done  out  1  one-cycle pulse when a bank fills.
REQ-016 frame_bank  out  1  index of the bank that just filled; valid while frame_done is high and held until the next frame_done.
REQ-017 full  out  2  per-bank full flags.
REQ-018 ovf  out  1  sticky flag: a sample was dropped.

Function
REQ-019 The FSM SHALL have states IDLE, CAPTURE and WAIT.
REQ-020 IDLE->CAPTURE SHALL occur when arm=1 and full[cur_bank]=0; otherwise IDLE->WAIT when arm=1.
REQ-021 A valid accepted in CAPTURE at cycle t SHALL produce N_CH writes on cycles t+1..t+N_CH, with channel k written at t+1+k.
REQ-022 Each write cycle SHALL drive enable=we=1, din=datos channel k, and addr = ((cur_bank*DEPTH) + samp_idx*N_CH + k) << 2.
REQ-023 In non-write cycles enable and we SHALL be 0; addr and din hold their last values.
REQ-024 A valid arriving while the serializer is still busy SHALL be dropped and SHALL set ovf.
REQ-025 The frame length SHALL be DEPTH/N_CH samples; samp_idx counts 0..DEPTH/N_CH-1.
REQ-026 The cycle after the final write of a frame: frame_done=1, frame_bank=cur_bank, full[cur_bank] set, cur_bank toggles, samp_idx wraps to 0.
REQ-027 After a frame: if arm=0, go to IDLE; else if full[new cur_bank]=1, go to WAIT; else stay in CAPTURE.
REQ-028 Deasserting arm mid-frame SHALL NOT abort the frame; the frame completes, then the FSM enters IDLE.
REQ-029 A valid arriving in WAIT or IDLE-with-arm=1 SHALL be dropped and SHALL set ovf; a valid with arm=0 in IDLE SHALL be ignored silently.
REQ-030 rel_ack SHALL clear full[rel_bank] on the next edge; rel_ack for a non-full bank SHALL be ignored.
REQ-031 WAIT->CAPTURE SHALL occur on the cycle after full[cur_bank] clears; WAIT->IDLE occurs if arm=0.
REQ-032 If rel_ack and a frame completion target the same bank in the same cycle, the set SHALL win (full=1).
REQ-033 ovf SHALL clear on rst or on an arm rising edge.

Reset
REQ-034 rst SHALL set state=IDLE, cur_bank=0, samp_idx=0, serializer idle, full=00, ovf=0, frame_done=0, frame_bank=0, enable=we=0, addr=0, din=0.
REQ-035 rst mid-frame SHALL discard the partial frame and any writes still pending, with no trailing writes.

Configuration
REQ-036 With macro BRAM_CAPTURE_OVF_CNT_EN defined, the block SHALL add output ovf_cnt [15:0], counting dropped samples, saturating at 0xFFFF and cleared like ovf.
REQ-037 Without BRAM_CAPTURE_OVF_CNT_EN, ovf_cnt SHALL NOT exist, and only the sticky ovf flag SHALL remain.

Structure
REQ-038 Package bram_capture_pkg SHALL hold the FSM state typedef, BYTE_SHIFT=2, and the default values of DATA_W, N_CH and ADDR_W.
REQ-039 The channel serializer SHALL be the sub-module bram_capture_ser, which registers datos on valid and emits N_CH channel words with a channel index and a busy flag.

Verification
REQ-040 With N_CH=2, ADDR_W=4, arm=1, valid every 2 cycles with datos={0x0B,0x0A}: writes SHALL go to addr 0x00=0x0A then 0x04=0x0B, and so on; frame_done SHALL pulse with frame_bank=0 after the 16th write (8 samples); the next write SHALL go to addr 0x40.
REQ-041 With full=11 and the FSM in WAIT, a valid SHALL give ovf=1 and no write; after rel_ack with rel_bank=0, CAPTURE SHALL resume and the next write SHALL go to addr 0x00.
REQ-042 With N_CH=2, valid on two consecutive cycles: the second sample SHALL be dropped, ovf SHALL be 1, and exactly 2 writes SHALL occur.
REQ-043 Asserting rst at the 5th write of a frame SHALL give enable=we=0 the next cycle and full=00; after re-arming, the first write SHALL go to addr 0x00.
REQ-044 Dropping arm at sample 3 of 8 SHALL let the frame complete (frame_done=1), and the FSM SHALL then enter IDLE with no further writes.
REQ-045 With BRAM_CAPTURE_OVF_CNT_EN defined, 3 dropped samples SHALL give ovf_cnt=3, and an arm rising edge SHALL reset it to 0.

Source files
------------

// File: rtl/bram_capture_pkg.sv
// Shared types and defaults for the ping-pong BRAM capture block.
package bram_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  localparam int unsigned BYTE_SHIFT = 2;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_N_CH   = 2;
  localparam int unsigned DEF_ADDR_W = 10;

endpackage

// File: rtl/bram_capture_ser.sv
// Channel serializer: latches a multi-channel sample and emits one channel word per cycle.
module bram_capture_ser
  import bram_capture_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_CH   = DEF_N_CH,
  parameter int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_CH*DATA_W-1:0] datos,
  output logic                   busy,
  output logic                   emit_c,
  output logic [DATA_W-1:0]      word_c,
  output logic [CH_W-1:0]        ch_c,
  output logic                   last_c
);

  localparam int unsigned LAST_CH = N_CH - 1;

  logic [N_CH-1:0][DATA_W-1:0] hold;
  logic [CH_W-1:0]             cnt;

  // Channel 0 goes out on the accept edge; busy covers the remaining channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      hold <= datos;
      cnt  <= CH_W'(1);
      busy <= (N_CH > 1);
    end else if (busy) begin
      if (cnt == CH_W'(LAST_CH)) begin
        busy <= 1'b0;
      end
      cnt <= cnt + CH_W'(1);
    end
  end

  always_comb begin
    emit_c = start | busy;
    word_c = hold[cnt];
    ch_c   = cnt;
    last_c = (cnt == CH_W'(LAST_CH));
    if (start) begin
      word_c = datos[DATA_W-1:0];
      ch_c   = '0;
      last_c = (N_CH == 1);
    end
  end

endmodule

// File: rtl/bram_capture_pp.sv
// Ping-pong BRAM capture: serializes multi-channel samples into two alternating banks.
// Optional BRAM_CAPTURE_OVF_CNT_EN adds a saturating dropped-sample counter output.
module bram_capture_pp
  import bram_capture_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_CH   = DEF_N_CH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   valid,
  input  logic [N_CH*DATA_W-1:0] datos,
  input  logic                   rel_ack,
  input  logic                   rel_bank,
  output logic                   enable,
  output logic                   we,
  output logic [31:0]            addr,
  output logic [31:0]            din,
  output logic                   frame_done,
  output logic                   frame_bank,
  output logic [1:0]             full,
  output logic                   ovf
`ifdef BRAM_CAPTURE_OVF_CNT_EN
  , output logic [15:0]          ovf_cnt
`endif
);

  localparam int unsigned DEPTH     = 32'(1) << ADDR_W;
  localparam int unsigned LOG_N     = $clog2(N_CH);
  localparam int unsigned CH_W      = (N_CH > 1) ? LOG_N : 1;
  localparam int unsigned FRAME_LEN = DEPTH / N_CH;
  localparam int unsigned SAMP_W    = (ADDR_W > LOG_N) ? ADDR_W - LOG_N : 1;
  localparam int unsigned LAST_SAMP = FRAME_LEN - 1;

  state_t              state, state_nxt;
  logic                cur_bank;
  logic [SAMP_W-1:0]   samp_idx;
  logic                fin_pend;
  logic                wr_last;
  logic                arm_q;
  logic [31:0]         word_base;

  logic                ser_busy, emit_c, last_c;
  logic [DATA_W-1:0]   word_c;
  logic [CH_W-1:0]     ch_c;

  logic                accept_c, drop_c, idle_exit_c, frame_end_c, arm_rise_c;
  logic [1:0]          full_nxt_c;
  logic [31:0]         base_c, sel_base_c;

  bram_capture_ser #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH),
    .CH_W   (CH_W)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .start  (accept_c),
    .datos  (datos),
    .busy   (ser_busy),
    .emit_c (emit_c),
    .word_c (word_c),
    .ch_c   (ch_c),
    .last_c (last_c)
  );

  // Acceptance, drop and frame-boundary decisions.
  always_comb begin
    frame_end_c = fin_pend & enable & wr_last;
    idle_exit_c = (state == S_CAPTURE) & ~arm & (samp_idx == '0) & ~fin_pend;
    accept_c    = (state == S_CAPTURE) & valid & ~ser_busy & ~fin_pend & ~idle_exit_c;
    drop_c      = valid & (((state == S_IDLE) & arm) | (state == S_WAIT) |
                  ((state == S_CAPTURE) & ~idle_exit_c & (ser_busy | fin_pend)));
    arm_rise_c  = arm & ~arm_q;
    base_c      = (32'(cur_bank) << ADDR_W) | (32'(samp_idx) << LOG_N);
    sel_base_c  = accept_c ? base_c : word_base;
    full_nxt_c  = full;
    if (rel_ack) begin
      full_nxt_c[rel_bank] = 1'b0;
    end
    // A completing frame wins over a release of the same bank.
    if (frame_end_c) begin
      full_nxt_c[cur_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (arm) begin
          state_nxt = full[cur_bank] ? S_WAIT : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (frame_end_c) begin
          if (!arm) begin
            state_nxt = S_IDLE;
          end else if (full[~cur_bank]) begin
            state_nxt = S_WAIT;
          end
        end else if (idle_exit_c) begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!arm) begin
          state_nxt = S_IDLE;
        end else if (!full[cur_bank]) begin
          state_nxt = S_CAPTURE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write port, frame bookkeeping and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_bank   <= 1'b0;
      samp_idx   <= '0;
      fin_pend   <= 1'b0;
      wr_last    <= 1'b0;
      arm_q      <= 1'b0;
      word_base  <= '0;
      enable     <= 1'b0;
      we         <= 1'b0;
      addr       <= '0;
      din        <= '0;
      frame_done <= 1'b0;
      frame_bank <= 1'b0;
      full       <= '0;
      ovf        <= 1'b0;
    end else begin
      arm_q      <= arm;
      full       <= full_nxt_c;
      frame_done <= frame_end_c;
      enable     <= emit_c;
      we         <= emit_c;
      wr_last    <= emit_c & last_c;
      ovf        <= (arm_rise_c ? 1'b0 : ovf) | drop_c;
      if (emit_c) begin
        din  <= 32'(word_c);
        addr <= (sel_base_c + 32'(ch_c)) << BYTE_SHIFT;
      end
      if (accept_c) begin
        word_base <= base_c;
        if (samp_idx == SAMP_W'(LAST_SAMP)) begin
          fin_pend <= 1'b1;
        end else begin
          samp_idx <= samp_idx + SAMP_W'(1);
        end
      end
      if (frame_end_c) begin
        frame_bank <= cur_bank;
        cur_bank   <= ~cur_bank;
        samp_idx   <= '0;
        fin_pend   <= 1'b0;
      end
    end
  end

`ifdef BRAM_CAPTURE_OVF_CNT_EN
  logic [15:0] cnt_base_c;

  always_comb begin
    cnt_base_c = arm_rise_c ? 16'd0 : ovf_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (drop_c && (cnt_base_c != 16'hFFFF)) begin
      ovf_cnt <= cnt_base_c + 16'd1;
    end else begin
      ovf_cnt <= cnt_base_c;
    end
  end
`endif

endmodule

// File: tb/tb_bram_capture_pp.sv
// Self-checking bench for bram_capture_pp (N_CH=2, ADDR_W=4, DATA_W=8).
module tb_bram_capture_pp;

  localparam int DW    = 8;
  localparam int NC    = 2;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int FRAME = DEPTH / NC;

  logic            clk = 1'b0;
  logic            rst, arm, valid, rel_ack, rel_bank;
  logic [NC*DW-1:0] datos;
  logic            enable, we, frame_done, frame_bank, ovf;
  logic [31:0]     addr, din;
  logic [1:0]      full;
`ifdef BRAM_CAPTURE_OVF_CNT_EN
  logic [15:0]     ovf_cnt;
`endif

  always #5 clk = ~clk;

  bram_capture_pp #(.DATA_W(DW), .N_CH(NC), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .valid      (valid),
    .datos      (datos),
    .rel_ack    (rel_ack),
    .rel_bank   (rel_bank),
    .enable     (enable),
    .we         (we),
    .addr       (addr),
    .din        (din),
    .frame_done (frame_done),
    .frame_bank (frame_bank),
    .full       (full),
    .ovf        (ovf)
`ifdef BRAM_CAPTURE_OVF_CNT_EN
    , .ovf_cnt  (ovf_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: pending writes as a queue, frame progress as sample counts.
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         m_q[$];
  int          m_state;  // 0 idle, 1 capture, 2 wait
  bit          m_bank, m_closing, m_en, m_fd, m_fb, m_ovf, m_arm_q;
  int          m_nsamp, m_cnt;
  bit [1:0]    m_full;
  logic [31:0] m_addr, m_din;

  task automatic model_step();
    bit done, busy, drop, acc, leave, rise;
    bit [1:0] full_old;
    int nxt;
    wr_t w;
    if (rst) begin
      m_q.delete();
      m_state = 0; m_bank = 0; m_closing = 0; m_en = 0; m_fd = 0; m_fb = 0;
      m_ovf = 0; m_arm_q = 0; m_nsamp = 0; m_cnt = 0; m_full = 0;
      m_addr = 0; m_din = 0;
      return;
    end
    full_old = m_full;
    done  = m_closing && (m_q.size() == 0) && m_en;
    busy  = (m_q.size() > 0) || m_closing;
    leave = (m_state == 1) && !arm && (m_nsamp == 0) && !m_closing;
    drop = 0; acc = 0;
    if (valid) begin
      if (m_state == 0) drop = arm;
      else if (m_state == 2) drop = 1;
      else if (!leave) begin
        if (busy) drop = 1; else acc = 1;
      end
    end
    if (acc) begin
      for (int k = 0; k < NC; k++) begin
        w.a = 32'((m_bank * DEPTH + m_nsamp * NC + k) * 4);
        w.d = 32'(datos[k*DW +: DW]);
        m_q.push_back(w);
      end
      if (m_nsamp == FRAME - 1) m_closing = 1; else m_nsamp++;
    end
    m_en = 0;
    if (m_q.size() > 0) begin
      w = m_q.pop_front();
      m_en = 1; m_addr = w.a; m_din = w.d;
    end
    if (rel_ack) m_full[rel_bank] = 0;
    m_fd = done;
    nxt = m_state;
    case (m_state)
      0: if (arm) nxt = full_old[m_bank] ? 2 : 1;
      1: if (done) nxt = !arm ? 0 : (full_old[!m_bank] ? 2 : 1);
         else if (leave) nxt = 0;
      default: if (!arm) nxt = 0; else if (!full_old[m_bank]) nxt = 1;
    endcase
    if (done) begin
      m_full[m_bank] = 1; m_fb = m_bank; m_bank = !m_bank;
      m_nsamp = 0; m_closing = 0;
    end
    m_state = nxt;
    rise = arm && !m_arm_q;
    m_arm_q = arm;
    m_ovf = (rise ? 1'b0 : m_ovf) | drop;
    if (rise) m_cnt = 0;
    if (drop && m_cnt < 65535) m_cnt++;
  endtask

  int          wr_cnt, fd_cnt;
  logic [31:0] obs_a[$], obs_d[$];

  // One clock: edge, model update, sample outputs at the falling edge.
  task automatic tick(input bit r, input bit a, input bit v, input logic [15:0] d,
                      input bit ra = 1'b0, input bit rb = 1'b0);
    rst = r; arm = a; valid = v; datos = d; rel_ack = ra; rel_bank = rb;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("enable", 32'(enable), 32'(m_en));
    chk("we", 32'(we), 32'(m_en));
    chk("addr", addr, m_addr);
    chk("din", din, m_din);
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("frame_bank", 32'(frame_bank), 32'(m_fb));
    chk("full", 32'(full), 32'(m_full));
    chk("ovf", 32'(ovf), 32'(m_ovf));
`ifdef BRAM_CAPTURE_OVF_CNT_EN
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
`endif
    if (enable) begin
      wr_cnt++;
      obs_a.push_back(addr);
      obs_d.push_back(din);
    end
    if (frame_done) fd_cnt++;
  endtask

  task automatic clr_obs();
    wr_cnt = 0; fd_cnt = 0;
    obs_a.delete(); obs_d.delete();
  endtask

  typedef struct {
    bit r, a, v; logic [15:0] d;
    bit en; logic [31:0] ad, dn; bit ov; logic [1:0] fl;
  } vec_t;

  vec_t tbl[6];
  bit   rarm;

  initial begin
    rst = 1; arm = 0; valid = 0; datos = 0; rel_ack = 0; rel_bank = 0;

    // Reset followed by back-to-back valids: second sample dropped.
    tbl[0] = '{1, 0, 0, 16'h0000, 0, 32'h00, 32'h00, 0, 2'b00};
    tbl[1] = '{0, 1, 0, 16'h0000, 0, 32'h00, 32'h00, 0, 2'b00};
    tbl[2] = '{0, 1, 1, 16'h0B0A, 1, 32'h00, 32'h0A, 0, 2'b00};
    tbl[3] = '{0, 1, 1, 16'h0D0C, 1, 32'h04, 32'h0B, 1, 2'b00};
    tbl[4] = '{0, 1, 0, 16'h0000, 0, 32'h04, 32'h0B, 1, 2'b00};
    tbl[5] = '{0, 1, 0, 16'h0000, 0, 32'h04, 32'h0B, 1, 2'b00};
    clr_obs();
    for (int i = 0; i < 6; i++) begin
      tick(tbl[i].r, tbl[i].a, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_en", i), 32'(enable), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_addr", i), addr, tbl[i].ad);
      chk($sformatf("tbl%0d_din", i), din, tbl[i].dn);
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].fl));
    end
    chk("tbl_writes", 32'(wr_cnt), 32'd2);

    // Full frame into bank 0, then first write of bank 1.
    tick(1, 0, 0, 0);
    clr_obs();
    tick(0, 1, 0, 0);
    for (int i = 0; i < FRAME; i++) begin
      tick(0, 1, 1, 16'h0B0A);
      tick(0, 1, 0, 0);
    end
    chk("frame_writes", 32'(wr_cnt), 32'd16);
    chk("first_addr", obs_a[0], 32'h00);
    chk("first_din", obs_d[0], 32'h0A);
    chk("second_addr", obs_a[1], 32'h04);
    chk("second_din", obs_d[1], 32'h0B);
    chk("last_addr", obs_a[15], 32'h3C);
    tick(0, 1, 0, 0);
    chk("fd_pulse", 32'(frame_done), 32'd1);
    chk("fd_bank", 32'(frame_bank), 32'd0);
    chk("fd_full", 32'(full), 32'b01);
    tick(0, 1, 1, 16'h0B0A);
    chk("bank1_addr", addr, 32'h40);
    chk("bank1_en", 32'(enable), 32'd1);
    tick(0, 1, 0, 0);
    chk("bank1_addr2", addr, 32'h44);

    // Fill bank 1, stall in WAIT, release bank 0 and resume.
    for (int i = 1; i < FRAME; i++) begin
      tick(0, 1, 1, 16'h2211);
      tick(0, 1, 0, 0);
    end
    tick(0, 1, 0, 0);
    chk("fd1_bank", 32'(frame_bank), 32'd1);
    chk("both_full", 32'(full), 32'b11);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 16'h3333);
    chk("wait_drop_ovf", 32'(ovf), 32'd1);
    chk("wait_drop_en", 32'(enable), 32'd0);
    tick(0, 1, 0, 0, 1, 0);
    chk("rel_full", 32'(full), 32'b10);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 16'h4455);
    chk("resume_en", 32'(enable), 32'd1);
    chk("resume_addr", addr, 32'h00);
    chk("resume_din", din, 32'h55);

    // Reset on the 5th write of the frame.
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 16'h6677);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 16'h8899);
    chk("w5_en", 32'(enable), 32'd1);
    tick(1, 1, 0, 0);
    chk("rst_en", 32'(enable), 32'd0);
    chk("rst_full", 32'(full), 32'b00);
    tick(0, 0, 0, 0);
    chk("rst_no_trail", 32'(enable), 32'd0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 16'hAABB);
    chk("rearm_addr", addr, 32'h00);
    chk("rearm_en", 32'(enable), 32'd1);

    // arm dropped at sample 3: frame completes, then idle.
    tick(1, 0, 0, 0);
    clr_obs();
    tick(0, 1, 0, 0);
    for (int i = 0; i < FRAME; i++) begin
      tick(0, i < 3, 1, 16'(i * 3 + 1));
      tick(0, i < 3, 0, 0);
    end
    tick(0, 0, 0, 0);
    chk("disarm_fd", 32'(frame_done), 32'd1);
    tick(0, 0, 1, 16'h1234);
    tick(0, 0, 1, 16'h1234);
    tick(0, 0, 0, 0);
    chk("disarm_writes", 32'(wr_cnt), 32'd16);
    chk("disarm_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("disarm_ovf", 32'(ovf), 32'd0);

`ifdef BRAM_CAPTURE_OVF_CNT_EN
    // Three busy drops, then an arm rising edge clears the count.
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 1, 1, 16'h0102);
    chk("cnt_three", 32'(ovf_cnt), 32'd3);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    chk("cnt_cleared", 32'(ovf_cnt), 32'd0);
    chk("cnt_ovf_cleared", 32'(ovf), 32'd0);
`endif

    // Randomized traffic against the model.
    tick(1, 0, 0, 0);
    rarm = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rarm = !rarm;
      tick($urandom_range(0, 799) == 0, rarm, $urandom_range(0, 2) == 0,
           16'($urandom), $urandom_range(0, 9) == 0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
